// File: rtl/dma_mem_lane_monitor.sv
// DMA->memory-controller lane monitor: round-robin capture of accepted writes into a time-stamped
// show-ahead FIFO, per-lane outstanding-read tracking and sticky errors. Option: DMA_MON_ADDR_FILTER_EN.
module dma_mem_lane_monitor #(
  parameter int NUM_LANES   = 32,
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int TS_WIDTH    = 16,
  parameter int OUTST_WIDTH = 4,
  localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset_poweron,
  input  logic                                    mon_enable,
  input  logic                                    mon_clear,
  input  logic [NUM_LANES-1:0]                    dma__memc__write_valid,
  input  logic [NUM_LANES-1:0]                    memc__dma__write_ready,
  input  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]    dma__memc__write_address,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    dma__memc__write_data,
  input  logic [NUM_LANES-1:0]                    dma__memc__read_valid,
  input  logic [NUM_LANES-1:0]                    memc__dma__read_ready,
  input  logic [NUM_LANES-1:0]                    memc__dma__read_data_valid,
`ifdef DMA_MON_ADDR_FILTER_EN
  input  logic [ADDR_WIDTH-1:0]                   tb__mon__win_base,
  input  logic [ADDR_WIDTH-1:0]                   tb__mon__win_limit,
`endif
  output logic                                    mon__tb__cap_valid,
  input  logic                                    tb__mon__cap_ready,
  output logic [LANE_W-1:0]                       mon__tb__cap_lane,
  output logic [ADDR_WIDTH-1:0]                   mon__tb__cap_addr,
  output logic [DATA_WIDTH-1:0]                   mon__tb__cap_data,
  output logic [TS_WIDTH-1:0]                     mon__tb__cap_ts,
  output logic [NUM_LANES-1:0][OUTST_WIDTH-1:0]   mon__tb__outstanding,
  output logic [NUM_LANES-1:0]                    mon__tb__err_drop,
  output logic [NUM_LANES-1:0]                    mon__tb__err_underflow,
  output logic [NUM_LANES-1:0]                    mon__tb__err_overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = LANE_W + ADDR_WIDTH + DATA_WIDTH + TS_WIDTH;

  // Reset asserts asynchronously, releases two clocks later in the clk domain.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  always_ff @(posedge clk or negedge reset_poweron)
    if (!reset_poweron) r_rst_sync <= '0;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];

  logic [TS_WIDTH-1:0] r_ts;
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n)       r_ts <= '0;
    else if (mon_clear) r_ts <= '0;
    else                r_ts <= r_ts + 1'b1;

  logic [NUM_LANES-1:0]                 w_in_win, w_ev, w_hv, w_grant;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] w_haddr;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_hdata;
  logic [NUM_LANES-1:0][TS_WIDTH-1:0]   w_hts;
  logic [LANE_W-1:0]                    r_ptr, w_gidx;
  logic                                 w_gvld, w_push, w_pop, w_full, w_empty;

`ifdef DMA_MON_ADDR_FILTER_EN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_win
    assign w_in_win[i] = (dma__memc__write_address[i] >= tb__mon__win_base) &&
                         (dma__memc__write_address[i] <= tb__mon__win_limit);
  end
`else
  assign w_in_win = '1;
`endif

  assign w_ev = dma__memc__write_valid & memc__dma__write_ready & w_in_win & {NUM_LANES{mon_enable}};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic                   r_hv, r_edrop, r_eunf, r_eovf;
    logic [ADDR_WIDTH-1:0]  r_haddr;
    logic [DATA_WIDTH-1:0]  r_hdata;
    logic [TS_WIDTH-1:0]    r_hts;
    logic [OUTST_WIDTH-1:0] r_cnt;
    logic                   w_inc, w_dec;

    assign w_inc      = dma__memc__read_valid[i] & memc__dma__read_ready[i];
    assign w_dec      = memc__dma__read_data_valid[i];
    assign w_grant[i] = w_push && (w_gidx == LANE_W'(i));

    // A grant frees the slot in the same cycle, so a new event can refill it without loss.
    always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
        r_hv <= 1'b0; r_haddr <= '0; r_hdata <= '0; r_hts <= '0;
      end else if (w_ev[i] && (!r_hv || w_grant[i])) begin
        r_hv    <= 1'b1;
        r_haddr <= dma__memc__write_address[i];
        r_hdata <= dma__memc__write_data[i];
        r_hts   <= r_ts;
      end else if (w_grant[i]) begin
        r_hv <= 1'b0;
      end

    always_ff @(posedge clk or negedge w_rst_n)
      if (!w_rst_n) begin
        r_cnt <= '0; r_edrop <= 1'b0; r_eunf <= 1'b0; r_eovf <= 1'b0;
      end else if (mon_clear) begin
        r_cnt <= '0; r_edrop <= 1'b0; r_eunf <= 1'b0; r_eovf <= 1'b0;
      end else begin
        if (w_ev[i] && r_hv && !w_grant[i]) r_edrop <= 1'b1;
        if (w_inc && !w_dec) begin
          if (&r_cnt) r_eovf <= 1'b1;
          else        r_cnt  <= r_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
          if (r_cnt == '0) r_eunf <= 1'b1;
          else             r_cnt  <= r_cnt - 1'b1;
        end
      end

    assign w_hv[i]                   = r_hv;
    assign w_haddr[i]                = r_haddr;
    assign w_hdata[i]                = r_hdata;
    assign w_hts[i]                  = r_hts;
    assign mon__tb__outstanding[i]   = r_cnt;
    assign mon__tb__err_drop[i]      = r_edrop;
    assign mon__tb__err_underflow[i] = r_eunf;
    assign mon__tb__err_overflow[i]  = r_eovf;
  end

  // Scan from the far end back to r_ptr so the nearest full slot at/after r_ptr wins.
  always_comb begin
    logic [LANE_W:0] idx;
    w_gvld = 1'b0;
    w_gidx = '0;
    idx    = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = {1'b0, r_ptr} + (LANE_W+1)'(k);
      if (idx >= (LANE_W+1)'(NUM_LANES)) idx = idx - (LANE_W+1)'(NUM_LANES);
      if (w_hv[idx[LANE_W-1:0]]) begin
        w_gvld = 1'b1;
        w_gidx = idx[LANE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n)    r_ptr <= '0;
    else if (w_push) r_ptr <= (w_gidx == LANE_W'(NUM_LANES - 1)) ? '0 : w_gidx + 1'b1;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wp, r_rp;
  logic [ENT_W-1:0] w_head;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[PTR_W] != r_rp[PTR_W]) && (r_wp[PTR_W-1:0] == r_rp[PTR_W-1:0]);
  assign w_pop   = !w_empty && tb__mon__cap_ready;
  assign w_push  = w_gvld && (!w_full || w_pop);

  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[PTR_W-1:0]] <= {w_gidx, w_haddr[w_gidx], w_hdata[w_gidx], w_hts[w_gidx]};

  // Storage is not reset; zero the head fields whenever nothing is held.
  assign w_head             = w_empty ? '0 : r_mem[r_rp[PTR_W-1:0]];
  assign mon__tb__cap_valid = !w_empty;
  assign {mon__tb__cap_lane, mon__tb__cap_addr, mon__tb__cap_data, mon__tb__cap_ts} = w_head;
endmodule

// File: tb/tb_dma_mem_lane_monitor.sv
// Scoreboard bench for dma_mem_lane_monitor: expected capture entries are queued as writes are
// driven and compared as the FIFO is drained; counters and errors are checked in-line.
module tb_dma_mem_lane_monitor;
  localparam int NL = 32, AW = 24, DW = 32, FD = 16, TW = 16, OW = 4, LW = 5;

  logic clk = 1'b0;
  logic reset_poweron, mon_enable, mon_clear, cap_ready, cap_valid;
  logic [NL-1:0]         wv, wr, rv, rr, rdv, err_drop, err_unf, err_ovf;
  logic [NL-1:0][AW-1:0] waddr;
  logic [NL-1:0][DW-1:0] wdata;
  logic [NL-1:0][OW-1:0] outst;
  logic [LW-1:0]         cap_lane;
  logic [AW-1:0]         cap_addr;
  logic [DW-1:0]         cap_data;
  logic [TW-1:0]         cap_ts;
`ifdef DMA_MON_ADDR_FILTER_EN
  logic [AW-1:0]         win_base, win_limit;
`endif

  typedef struct packed {
    logic [LW-1:0] lane;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] ts;
  } ent_t;

  ent_t          sb_q[$];
  ent_t          mon_e;
  int            n_chk = 0, n_pass = 0, cyc;
  logic [TW-1:0] tb_ts = '0;

  always #5 clk = ~clk;

  dma_mem_lane_monitor #(
    .NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .TS_WIDTH(TW), .OUTST_WIDTH(OW)
  ) u_dut (
    .clk                        (clk),
    .reset_poweron              (reset_poweron),
    .mon_enable                 (mon_enable),
    .mon_clear                  (mon_clear),
    .dma__memc__write_valid     (wv),
    .memc__dma__write_ready     (wr),
    .dma__memc__write_address   (waddr),
    .dma__memc__write_data      (wdata),
    .dma__memc__read_valid      (rv),
    .memc__dma__read_ready      (rr),
    .memc__dma__read_data_valid (rdv),
`ifdef DMA_MON_ADDR_FILTER_EN
    .tb__mon__win_base          (win_base),
    .tb__mon__win_limit         (win_limit),
`endif
    .mon__tb__cap_valid         (cap_valid),
    .tb__mon__cap_ready         (cap_ready),
    .mon__tb__cap_lane          (cap_lane),
    .mon__tb__cap_addr          (cap_addr),
    .mon__tb__cap_data          (cap_data),
    .mon__tb__cap_ts            (cap_ts),
    .mon__tb__outstanding       (outst),
    .mon__tb__err_drop          (err_drop),
    .mon__tb__err_underflow     (err_unf),
    .mon__tb__err_overflow      (err_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every accepted pop is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_poweron && cap_valid && cap_ready) begin
      if (sb_q.size() == 0) chk("cap_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = sb_q.pop_front();
        chk("cap_lane", 64'(cap_lane), 64'(mon_e.lane));
        chk("cap_addr", 64'(cap_addr), 64'(mon_e.addr));
        chk("cap_data", 64'(cap_data), 64'(mon_e.data));
        chk("cap_ts",   64'(cap_ts),   64'(mon_e.ts));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    tb_ts = mon_clear ? '0 : tb_ts + 1'b1;
    #1;
  endtask

  task automatic wr1(input int l, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit exp);
    ent_t e;
    wv[l] = 1'b1; wr[l] = 1'b1; waddr[l] = a; wdata[l] = d;
    e.lane = LW'(l); e.addr = a; e.data = d; e.ts = tb_ts;
    if (exp) sb_q.push_back(e);
    step();
    wv[l] = 1'b0; wr[l] = 1'b0;
  endtask

  task automatic rd(input int l, input bit req, input bit ret);
    rv[l] = req; rr[l] = req; rdv[l] = ret;
    step();
    rv[l] = 1'b0; rr[l] = 1'b0; rdv[l] = 1'b0;
  endtask

  task automatic drain(input string tag, output int n);
    n = 0;
    cap_ready = 1'b1;
    while (sb_q.size() != 0 && n < 300) begin step(); n++; end
    chk({tag, "_left"}, 64'(sb_q.size()), 64'd0);
    step(); step();
    chk({tag, "_empty"}, 64'(cap_valid), 64'd0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_poweron = 1'b0; mon_enable = 1'b1; mon_clear = 1'b0; cap_ready = 1'b0;
    wv = '0; wr = '0; rv = '0; rr = '0; rdv = '0; waddr = '0; wdata = '0;
`ifdef DMA_MON_ADDR_FILTER_EN
    win_base = '0; win_limit = '1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cap_valid", 64'(cap_valid), 64'd0);
    chk("rst_outst",     64'(|outst), 64'd0);
    chk("rst_errs",      64'(|{err_drop, err_unf, err_ovf}), 64'd0);
    reset_poweron = 1'b1;
    repeat (4) step();
    mon_clear = 1'b1; step(); mon_clear = 1'b0;

    // All lanes at once: one grant per cycle, lane order 0..31 from a reset pointer.
    cap_ready = 1'b1;
    for (int i = 0; i < NL; i++) begin
      ent_t e;
      wv[i] = 1'b1; wr[i] = 1'b1;
      waddr[i] = 24'h001000 + AW'(i); wdata[i] = 32'hA5A50000 + DW'(i);
      e.lane = LW'(i); e.addr = waddr[i]; e.data = wdata[i]; e.ts = tb_ts;
      sb_q.push_back(e);
    end
    step();
    wv = '0; wr = '0;
    drain("arb", cyc);
    chk("arb_cycles", 64'(cyc), 64'd33);
    chk("arb_no_drop", 64'(err_drop), 64'd0);

    // Single write at ts 0x0010 with a 2-cycle capture latency and a stalled head.
    cap_ready = 1'b0;
    mon_clear = 1'b1; step(); mon_clear = 1'b0;
    repeat (16) step();
    wr1(3, 24'h000100, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("lat_n1_valid", 64'(cap_valid), 64'd0);
    step();
    @(negedge clk);
    chk("lat_n2_valid", 64'(cap_valid), 64'd1);
    chk("lat_n2_ts",    64'(cap_ts), 64'h10);
    step();
    chk("stall_addr",   64'(cap_addr), 64'h100);
    chk("stall_lane",   64'(cap_lane), 64'd3);
    drain("single", cyc);

    // Backpressure: 16 in FIFO, 17th held, 18th dropped.
    cap_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      wr1(0, 24'h002000 + AW'(k), DW'(k), k < 17);
      if (k == 16) chk("bp_no_drop_17", 64'(err_drop[0]), 64'd0);
    end
    wv = '0; wr = '0;
    chk("bp_drop_18",  64'(err_drop[0]), 64'd1);
    chk("bp_valid",    64'(cap_valid), 64'd1);
    drain("bp", cyc);

    // Outstanding reads on lane 5; tracking ignores mon_enable.
    mon_enable = 1'b0;
    wr1(4, 24'h000444, 32'h4, 1'b0);
    repeat (3) rd(5, 1'b1, 1'b0);
    chk("os_after_3req", 64'(outst[5]), 64'd3);
    repeat (2) rd(5, 1'b0, 1'b1);
    chk("os_after_2ret", 64'(outst[5]), 64'd1);
    chk("dis_no_cap",    64'(cap_valid), 64'd0);
    rd(5, 1'b1, 1'b1);
    chk("os_req_ret",    64'(outst[5]), 64'd1);
    rv[5] = 1'b1; step(); rv[5] = 1'b0;
    chk("os_no_ready",   64'(outst[5]), 64'd1);
    rd(5, 1'b0, 1'b1);
    chk("os_zero",       64'(outst[5]), 64'd0);
    chk("os_no_unf",     64'(err_unf[5]), 64'd0);
    rd(5, 1'b0, 1'b1);
    chk("os_unf",        64'(err_unf[5]), 64'd1);
    chk("os_unf_cnt",    64'(outst[5]), 64'd0);
    mon_enable = 1'b1;

    // Overflow on lane 1, then a clear that must leave the FIFO alone.
    for (int k = 0; k < 16; k++) begin
      rd(1, 1'b1, 1'b0);
      if (k == 14) begin
        chk("ovf_cnt15",   64'(outst[1]), 64'd15);
        chk("ovf_not_yet", 64'(err_ovf[1]), 64'd0);
      end
    end
    chk("ovf_set", 64'(err_ovf[1]), 64'd1);
    chk("ovf_sat", 64'(outst[1]), 64'd15);
    cap_ready = 1'b0;
    wr1(7, 24'h000777, 32'h00007777, 1'b1);
    step(); step();
    mon_clear = 1'b1; rdv[2] = 1'b1;
    step();
    mon_clear = 1'b0; rdv[2] = 1'b0;
    chk("clr_outst", 64'(|outst), 64'd0);
    chk("clr_ovf",   64'(err_ovf), 64'd0);
    chk("clr_unf",   64'(err_unf), 64'd0);
    chk("clr_drop",  64'(err_drop), 64'd0);
    chk("clr_fifo",  64'(cap_valid), 64'd1);
    drain("clr", cyc);

    // Reset mid-stream drops captured entries and zeroes every output at once.
    cap_ready = 1'b0;
    for (int k = 0; k < 3; k++) wr1(2, 24'h000A00 + AW'(k), 32'hCAFE0000 + DW'(k), 1'b1);
    rd(9, 1'b1, 1'b0);
    rd(10, 1'b0, 1'b1);
    step(); step();
    chk("pre_rst_valid", 64'(cap_valid), 64'd1);
    reset_poweron = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(cap_valid), 64'd0);
    chk("mid_rst_fields", 64'(|{cap_lane, cap_addr, cap_data, cap_ts}), 64'd0);
    chk("mid_rst_outst", 64'(|outst), 64'd0);
    chk("mid_rst_errs",  64'(|{err_drop, err_unf, err_ovf}), 64'd0);
    sb_q.delete();
    step();
    reset_poweron = 1'b1;
    repeat (4) step();
    chk("post_rst_valid", 64'(cap_valid), 64'd0);

`ifdef DMA_MON_ADDR_FILTER_EN
    win_base = 24'h000100; win_limit = 24'h0001FF;
    cap_ready = 1'b0;
    wr1(6, 24'h0000FF, 32'h1, 1'b0);
    wr1(6, 24'h000100, 32'h2, 1'b1);
    wr1(6, 24'h0001FF, 32'h3, 1'b1);
    wr1(6, 24'h000200, 32'h4, 1'b0);
    repeat (3) step();
    drain("win", cyc);
    win_base = 24'h000200; win_limit = 24'h000100;
    wr1(6, 24'h000180, 32'h5, 1'b0);
    repeat (3) step();
    chk("win_inverted", 64'(cap_valid), 64'd0);
    chk("win_no_drop",  64'(err_drop), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
